core_sequencer: RTL
===================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 15, max cycles a memory request may wait for ack (1..15).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports: im_req  out  1  instruction fetch request.
REQ-005 SHALL have ports: im_ack  in  1  fetch data valid.
REQ-006 SHALL have ports: dm_req  out  1  data memory request.
REQ-007 SHALL have ports: dm_ack  in  1  data access complete.
REQ-008 SHALL have ports: dec_regwrite, dec_csr_any, dec_mem, dec_store  in  1 each  decoder controls (dec_mem = byte enables nonzero).
REQ-009 SHALL have ports: dec_illegal, dec_unsupported, dec_load_mis, dec_store_mis  in  1 each  decoder exception flags.
REQ-010 SHALL have ports: ir_we, pc_we, rf_we, csr_we  out  1 each  state-element write strobes.
REQ-011 SHALL have ports: trap_enter  out  1, trap_cause  out  4, trap_is_irq  out  1  trap request to CSR file.
REQ-012 SHALL have ports: state  out  3  current state, debug.

Function
REQ-013 SHALL implement states FETCH, DECODE, MEM, WB, TRAP; encodings per shared package.
REQ-014 FETCH SHALL assert im_req every cycle until im_ack; on im_ack pulse ir_we one cycle and go DECODE.
REQ-015 DECODE (1 cycle) SHALL go TRAP if any dec_* exception flag set, else MEM if dec_mem, else WB.
REQ-016 Exception priority SHALL be unsupported (cause 2), illegal (2), load_mis (4), store_mis (6).
REQ-017 MEM SHALL assert dm_req every cycle until dm_ack, then go WB.
REQ-018 WB (1 cycle) SHALL pulse pc_we, rf_we=dec_regwrite, csr_we=dec_csr_any, then go FETCH.
REQ-019 TRAP (1 cycle) SHALL pulse trap_enter and pc_we with trap_cause valid, rf_we=csr_we=0, then go FETCH.
REQ-020 Minimum latency SHALL be 3 cycles (FETCH, DECODE, WB) for non-memory, 4 for memory, with single-cycle ack.
REQ-021 Watchdog SHALL clear on entry to FETCH/MEM, increment each cycle req is high without ack; at count==TIMEOUT go TRAP, cause 1 (fetch), 5 (load), 7 (store).
REQ-022 Ack in the same cycle the count reaches TIMEOUT SHALL win; no trap.
REQ-023 im_ack/dm_ack while the corresponding req is low SHALL be ignored.
REQ-024 Strobes SHALL be Moore outputs except ir_we (registered on im_ack cycle); no strobe pulses outside its state.

Reset
REQ-025 reset assertion SHALL immediately force state=FETCH, watchdog=0, all outputs 0, trap_cause=0.
REQ-026 im_req SHALL rise in the first clock after reset deassertion; reset mid-transfer abandons it with no strobe.

Configuration
REQ-027 With INTERRUPT_EN defined SHALL add port irq in 1; irq high in WB SHALL, after WB completes, enter TRAP with trap_is_irq=1, cause 11.
REQ-028 Without INTERRUPT_EN the irq port SHALL be absent and trap_is_irq tied 0.
REQ-029 irq SHALL never preempt DECODE, MEM, or an exception TRAP; synchronous exception wins.

Structure
REQ-030 State encodings, cause codes (1,2,4,5,6,7,11) SHALL live in a shared package.
REQ-031 Watchdog counter SHALL be sub-module seq_watchdog (clear, count, expired).

Verification
REQ-032 ADDI, im_ack in first FETCH cycle -> ir_we, then WB with pc_we=rf_we=1; 3 cycles total, back in FETCH.
REQ-033 LW, dm_ack after 4 MEM cycles -> dm_req high exactly 4 cycles, WB rf_we=1, no trap.
REQ-034 dec_illegal in DECODE -> TRAP, trap_enter=1, trap_cause=2, rf_we=0.
REQ-035 im_ack never (TIMEOUT=15) -> trap after 15 cycles cause 1; repeat with ack on 15th cycle -> no trap.
REQ-036 reset pulsed mid-MEM -> outputs 0 asynchronously, im_req high first cycle after release.
REQ-037 INTERRUPT_EN, irq high during WB of ADDI -> rf_we=1, then TRAP with trap_is_irq=1, cause 11.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared sequencer definitions: state encodings, trap cause codes and the
// decode-stage exception priority.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    WB     = 3'd3,
    TRAP   = 3'd4
  } seq_state_t;

  localparam logic [3:0] CAUSE_NONE          = 4'd0;
  localparam logic [3:0] CAUSE_FETCH_TIMEOUT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL       = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MIS      = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_TIMEOUT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MIS     = 4'd6;
  localparam logic [3:0] CAUSE_STORE_TIMEOUT = 4'd7;
  localparam logic [3:0] CAUSE_IRQ           = 4'd11;

  localparam int WD_W = 4;

  // Unsupported and illegal share a cause; misalignment checks rank below them.
  function automatic logic [3:0] exc_cause(input logic unsupported, input logic illegal,
                                           input logic load_mis, input logic store_mis);
    logic [3:0] c;
    c = CAUSE_NONE;
    if (unsupported || illegal) c = CAUSE_ILLEGAL;
    else if (load_mis)          c = CAUSE_LOAD_MIS;
    else if (store_mis)         c = CAUSE_STORE_MIS;
    return c;
  endfunction

endpackage

// File: rtl/core_sequencer_watchdog.sv
// Memory-request watchdog: counts stalled request cycles; expired fires in the
// cycle the count would reach TIMEOUT, so an ack in that same cycle still wins.
module seq_watchdog
  import core_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [WD_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (count) cnt <= cnt + {{(WD_W-1){1'b0}}, 1'b1};
  end

  assign expired = count && (cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer FETCH/DECODE/MEM/WB/TRAP with request watchdog.
// Optional interrupt entry after writeback is enabled by defining INTERRUPT_EN.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  output logic       im_req,
  input  logic       im_ack,
  output logic       dm_req,
  input  logic       dm_ack,
  input  logic       dec_regwrite,
  input  logic       dec_csr_any,
  input  logic       dec_mem,
  input  logic       dec_store,
  input  logic       dec_illegal,
  input  logic       dec_unsupported,
  input  logic       dec_load_mis,
  input  logic       dec_store_mis,
`ifdef INTERRUPT_EN
  input  logic       irq,
`endif
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       csr_we,
  output logic       trap_enter,
  output logic [3:0] trap_cause,
  output logic       trap_is_irq,
  output logic [2:0] state
);

  seq_state_t st, st_nxt;
  logic [3:0] cause_q, cause_nxt;
  logic       ir_we_q;
  logic       wd_clear, wd_count, wd_expired;
  logic       dec_exc;

  // The counter only runs while a request is outstanding; any other state
  // holds it at zero, so it starts fresh on every entry to FETCH or MEM.
  assign wd_clear = !(st == FETCH || st == MEM);
  assign wd_count = (st == FETCH && !im_ack) || (st == MEM && !dm_ack);
  assign dec_exc  = dec_unsupported || dec_illegal || dec_load_mis || dec_store_mis;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= FETCH;
      cause_q <= CAUSE_NONE;
      ir_we_q <= 1'b0;
    end else begin
      st      <= st_nxt;
      cause_q <= cause_nxt;
      ir_we_q <= (st == FETCH) && im_ack;
    end
  end

  always_comb begin
    st_nxt     = st;
    cause_nxt  = cause_q;
    im_req     = 1'b0;
    dm_req     = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    csr_we     = 1'b0;
    trap_enter = 1'b0;
    trap_cause = CAUSE_NONE;
    case (st)
      FETCH: begin
        // Held low during reset so every output is zero while reset is high.
        im_req = !reset;
        if (im_ack) begin
          st_nxt = DECODE;
        end else if (wd_expired) begin
          st_nxt    = TRAP;
          cause_nxt = CAUSE_FETCH_TIMEOUT;
        end
      end
      DECODE: begin
        if (dec_exc) begin
          st_nxt    = TRAP;
          cause_nxt = exc_cause(dec_unsupported, dec_illegal, dec_load_mis, dec_store_mis);
        end else if (dec_mem) begin
          st_nxt = MEM;
        end else begin
          st_nxt = WB;
        end
      end
      MEM: begin
        dm_req = 1'b1;
        if (dm_ack) begin
          st_nxt = WB;
        end else if (wd_expired) begin
          st_nxt    = TRAP;
          cause_nxt = dec_store ? CAUSE_STORE_TIMEOUT : CAUSE_LOAD_TIMEOUT;
        end
      end
      WB: begin
        pc_we  = 1'b1;
        rf_we  = dec_regwrite;
        csr_we = dec_csr_any;
        st_nxt = FETCH;
`ifdef INTERRUPT_EN
        // Interrupts are only taken at an instruction boundary.
        if (irq) begin
          st_nxt    = TRAP;
          cause_nxt = CAUSE_IRQ;
        end
`endif
      end
      TRAP: begin
        pc_we      = 1'b1;
        trap_enter = 1'b1;
        trap_cause = cause_q;
        cause_nxt  = CAUSE_NONE;
        st_nxt     = FETCH;
      end
      default: st_nxt = FETCH;
    endcase
  end

  assign ir_we = ir_we_q;
  assign state = st;

`ifdef INTERRUPT_EN
  assign trap_is_irq = (st == TRAP) && (cause_q == CAUSE_IRQ);
`else
  assign trap_is_irq = 1'b0;
`endif

endmodule
